// File: rtl/mux_comparacion_adelanto_pkg.sv
// mux_comparacion_adelanto_pkg: select codes, tag flag layout and stage indices (WB stage only with FWD_WB_EN)
package mux_comparacion_adelanto_pkg;
  localparam logic [1:0] SEL_DECO = 2'b00;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;
  localparam int STG_EXE = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB = 2;
`ifdef FWD_WB_EN
  localparam int N_STG = 3;
`else
  localparam int N_STG = 2;
`endif
  typedef struct packed {
    logic valid;
    logic we;
    logic load;
  } tag_t;
endpackage

// File: rtl/mux_comparacion_adelanto_n.sv
// mux_comparacion_n: per-channel operand mux driven by the forwarding select (WB leg only with FWD_WB_EN)
module mux_comparacion_n
  import mux_comparacion_adelanto_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] d_deco,
  input  logic [DATA_W-1:0] d_exe,
  input  logic [DATA_W-1:0] d_mem,
`ifdef FWD_WB_EN
  input  logic [DATA_W-1:0] d_wb,
`endif
  output logic [DATA_W-1:0] op
);
  always_comb begin
    op = (sel == SEL_EXE) ? d_exe :
         (sel == SEL_MEM) ? d_mem :
`ifdef FWD_WB_EN
         (sel == SEL_WB) ? d_wb :
`endif
         d_deco;
  end
endmodule

// File: rtl/mux_comparacion_adelanto.sv
// mux_comparacion_adelanto: branch-operand forwarding and load-use stall unit; FWD_WB_EN adds a WB forwarding stage
module mux_comparacion_adelanto
  import mux_comparacion_adelanto_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int N_OPS = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    deco_valid,
  input  logic                    deco_we,
  input  logic                    deco_load,
  input  logic [REG_AW-1:0]       deco_rd,
  input  logic [N_OPS-1:0]        use_op,
  input  logic [N_OPS*REG_AW-1:0] rs_addr,
  input  logic [N_OPS*DATA_W-1:0] rs_deco,
  input  logic [DATA_W-1:0]       res_exe,
  input  logic [DATA_W-1:0]       res_mem,
`ifdef FWD_WB_EN
  input  logic [DATA_W-1:0]       res_wb,
`endif
  input  logic                    flush,
  output logic [N_OPS*2-1:0]      sel_rs,
  output logic [N_OPS*DATA_W-1:0] op_comp,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_count
);
  tag_t              flg [N_STG];
  logic [REG_AW-1:0] rd  [N_STG];
  logic [N_OPS-1:0]  st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_STG; s++) begin
        flg[s] <= '0;
        rd[s] <= '0;
      end
      stall_count <= '0;
    end else begin
      flg[STG_EXE] <= (deco_valid && !stall && !flush) ? '{1'b1, deco_we, deco_load} : '0;
      rd[STG_EXE] <= deco_rd;
      for (int s = 1; s < N_STG; s++) begin
        flg[s] <= flg[s-1];
        rd[s] <= rd[s-1];
      end
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N_OPS; i++) begin : g_ch
    logic [REG_AW-1:0] a;
    logic [N_STG-1:0]  m;
    assign a = rs_addr[i*REG_AW +: REG_AW];
    for (genvar j = 0; j < N_STG; j++) begin : g_m
      assign m[j] = flg[j].valid & flg[j].we & (rd[j] == a) & (a != '0);
    end
    // an EXE load cannot forward yet: fall through to older stages and stall instead
    assign sel_rs[2*i +: 2] = (m[STG_EXE] && !flg[STG_EXE].load) ? SEL_EXE :
                              m[STG_MEM] ? SEL_MEM :
`ifdef FWD_WB_EN
                              m[STG_WB] ? SEL_WB :
`endif
                              SEL_DECO;
    assign st[i] = use_op[i] & deco_valid & m[STG_EXE] & flg[STG_EXE].load;
    mux_comparacion_n #(.DATA_W(DATA_W)) u_mux (
      .sel    (sel_rs[2*i +: 2]),
      .d_deco (rs_deco[i*DATA_W +: DATA_W]),
      .d_exe  (res_exe),
      .d_mem  (res_mem),
`ifdef FWD_WB_EN
      .d_wb   (res_wb),
`endif
      .op     (op_comp[i*DATA_W +: DATA_W])
    );
  end

  assign stall = |st;
endmodule

// File: doc/mux_comparacion_adelanto.md
Name: mux_comparacion_adelanto

Overview:
- Parametrised forwarding and hazard unit for the branch-comparison operands in the Deco stage.
- Tracks destination tags of in-flight instructions in Exe and Mem in an internal tag pipeline.
- Per operand channel, selects Deco, Exe or Mem data for the comparator; Mem is the next stage after Exe.
- Raises a stall when a required operand is still being loaded; counts stall cycles.
- Sits between the register file read ports, the Exe/Mem result buses and the comparison unit; drives the Deco hold and bubble control.

Parameters:
DATA_W, 32, operand/result width in bits
REG_AW, 5, register address width
N_OPS, 2, number of independent comparison operand channels
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
deco_valid  input  1  Deco holds a valid instruction
deco_we  input  1  Deco instruction writes a register
deco_load  input  1  Deco instruction is a load
deco_rd  input  REG_AW  Deco destination register
use_op  input  N_OPS  channel i is read by the comparator this cycle
rs_addr  input  N_OPS*REG_AW  source register per channel, channel i at [i*REG_AW +: REG_AW]
rs_deco  input  N_OPS*DATA_W  register-file data per channel
res_exe  input  DATA_W  Exe-stage ALU result
res_mem  input  DATA_W  Mem-stage result, load data included
flush  input  1  squash the Deco instruction
sel_rs  output  N_OPS*2  per-channel select: 00 Deco, 01 Exe, 10 Mem
op_comp  output  N_OPS*DATA_W  selected operand per channel
stall  output  1  hold Deco/Fetch this cycle
stall_count  output  CNT_W  saturating count of stall cycles

Behaviour:
- Tag pipeline has 2 entries, EXE and MEM. Each entry holds {valid, we, load, rd}.
- Reset, asynchronous: all entry valid bits = 0, stall_count = 0.
  - Immediately after reset: sel_rs = 0, stall = 0, op_comp = rs_deco.
- Each rising edge:
  - MEM <= EXE.
  - EXE <= Deco info when deco_valid & !stall & !flush.
  - Otherwise EXE <= bubble (valid = 0).
- Match for channel i at stage S: S.valid & S.we & (S.rd == rs_addr_i) & (rs_addr_i != 0). Register 0 never forwards.
- sel_rs_i, combinational, youngest producer wins:
  - EXE match and not load → 01.
  - Else MEM match → 10.
  - Else → 00.
  - An EXE load match selects as if EXE did not match; stall is then high.
- op_comp_i = mux(sel_rs_i), combinational, zero latency. Code 11 is unreachable; op_comp decodes it to rs_deco.
- stall = OR over i of (use_op_i & deco_valid & EXE match_i & EXE.load).
  - Load-use through the comparator costs exactly 1 cycle.
  - Next cycle the load is in MEM and sel_rs_i = 10.
- An unused channel (use_op_i = 0) never stalls. Its sel_rs_i is still computed.
- flush and stall in the same cycle: bubble is pushed; stall output is still driven. Upstream treats flush as dominant.
- stall_count increments on each cycle with stall = 1 and saturates at all-ones; no wrap.
- Reset asserted mid-stall clears the pipeline asynchronously. stall drops to 0 the same cycle.
- Both channels may match different stages independently. Both channels may name the same register.

Optional Feature:
- Macro: FWD_WB_EN.
- Defined:
  - Adds a third tag entry, WB <= MEM.
  - Adds input res_wb (DATA_W).
  - Select code 11 = WB, lowest forwarding priority (EXE > MEM > WB > Deco).
  - Covers register files without write-before-read.
- Undefined: no WB entry, no res_wb port; code 11 is unreachable.

Decomposition:
- Shared package/header holds:
  - Select encodings: SEL_DECO = 2'b00, SEL_EXE = 2'b01, SEL_MEM = 2'b10, SEL_WB = 2'b11.
  - The tag entry struct/field layout {valid, we, load, rd}.
  - Entry index constants.
- One natural sub-module: mux_comparacion_n, the per-channel operand mux, instantiated N_OPS times via generate.
- Tag pipeline, match logic and counter stay in the top.

Test Plan:
- Reset: assert rst mid-run with EXE holding a load to r3 and use_op = 01, rs_addr0 = 3 → stall = 0, sel_rs = 0, stall_count = 0 immediately.
- ALU forward: push add r5 (we = 1, load = 0); next cycle rs_addr0 = 5, res_exe = 0x0000_00AA → sel_rs0 = 01, op_comp0 = 0xAA, stall = 0; following cycle → sel_rs0 = 10 with res_mem.
- Load-use: push lw r7; next cycle use_op0 = 1, rs_addr0 = 7 → stall = 1 for exactly 1 cycle; then sel_rs0 = 10, op_comp0 = res_mem = 0xDEAD_BEEF; stall_count = 1.
- Priority and r0: EXE and MEM both write r4 → sel_rs = 01; a producer writing r0 with rs_addr = 0 → sel_rs = 00.
- Flush and dual channel: flush with deco_valid = 1 → EXE bubble, no later match; channel0 = r2 from EXE and channel1 = r9 from MEM in the same cycle → sel_rs = {10, 01}.
- Saturation: with CNT_W = 4, hold a load-use stall for 20 cycles by re-issuing the load → stall_count stops at 0xF.
